cfg_reg_bank: RTL and testbench
===============================

CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 4; number of configuration registers, legal range 1..16.
REQ-002 Parameter DATA_W, default 8; width of every register, legal range 1..32.
REQ-003 Parameter ADDR_W, default 4; address width, and 2^ADDR_W SHALL be at least NUM_REGS.
REQ-004 Parameter RST_VALS, default {8'd0, 8'd0, 8'd0, 8'd25}; packed NUM_REGS*DATA_W reset image, with register 0 in the LSBs.
REQ-005 Parameter IMMEDIATE, default 0; when 1, a write updates the active copy in the same edge as the shadow copy.
REQ-006 PCIE_dma_engine_clk  in  1  sole clock; all state is updated on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  write strobe, one write per asserted cycle.
REQ-009 wr_addr  in  ADDR_W  write register index.
REQ-010 wr_data  in  DATA_W  write value.
REQ-011 rd_en  in  1  read strobe.
REQ-012 rd_addr  in  ADDR_W  read register index.
REQ-013 rd_src  in  1  read source select: 0 = shadow copy, 1 = active copy.
REQ-014 rd_data  out  DATA_W  read result, registered.
REQ-015 rd_valid  out  1  one-cycle qualifier for rd_data.
REQ-016 commit_req  in  1  pulse that arms transfer of shadow to active.
REQ-017 frame_sync  in  1  pulse marking the apply point, the acquisition frame boundary.
REQ-018 active_regs  out  NUM_REGS*DATA_W  active configuration image, packed like RST_VALS.
REQ-019 commit_pending  out  1  high while a commit is armed and not yet applied.
REQ-020 update_pulse  out  1  one-cycle pulse on the cycle after active_regs changes through a commit.
REQ-021 addr_err  out  1  one-cycle pulse for an out-of-range write or read.
REQ-022 commit_cnt  out  8  count of applied commits.

Function
REQ-023 Write path: wr_en with wr_addr < NUM_REGS SHALL load shadow[wr_addr] at the next edge.
REQ-024 Write addr_err: wr_en with wr_addr >= NUM_REGS SHALL leave all state unchanged and pulse addr_err in the following cycle.
REQ-025 Read latency: rd_en SHALL produce rd_data and rd_valid exactly one cycle later, sourced from the copy selected by rd_src.
REQ-026 Read out of range: an out-of-range rd_addr SHALL return rd_data = 0 with rd_valid = 1, and SHALL pulse addr_err.
REQ-027 Read/write collision: a read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-028 Commit state machine: two states, IDLE and PENDING; commit_pending SHALL equal (state == PENDING).
REQ-029 IDLE: commit_req without frame_sync SHALL move the FSM to PENDING.
REQ-030 IDLE: commit_req together with frame_sync SHALL apply the commit at that edge and the FSM SHALL stay in IDLE.
REQ-031 PENDING: frame_sync SHALL apply the commit and the FSM SHALL return to IDLE.
REQ-032 PENDING: a repeated commit_req SHALL have no additional effect.
REQ-033 Apply: all NUM_REGS active registers SHALL load the shadow values in a single edge, so software never sees a partial update.
REQ-034 Write during apply: a write in the apply cycle SHALL land in the shadow copy only, and the commit SHALL transfer the pre-write shadow value.
REQ-035 Apply outputs: update_pulse SHALL assert for exactly one cycle after each apply, and commit_cnt SHALL increment by 1 per apply, wrapping from 255 to 0.
REQ-036 frame_sync in IDLE without commit_req SHALL change no state.
REQ-037 IMMEDIATE mode: with IMMEDIATE = 1, a legal write SHALL update both shadow and active copies, the commit FSM SHALL remain operational, and a write by itself SHALL NOT assert update_pulse.
REQ-038 active_regs SHALL be driven directly from the active registers, with no combinational path from any input.

Reset
REQ-039 On rst_n low, shadow and active copies SHALL load RST_VALS asynchronously.
REQ-040 On rst_n low, the FSM SHALL go to IDLE, and rd_data, rd_valid, update_pulse, addr_err and commit_cnt SHALL be 0.
REQ-041 Reset while PENDING SHALL discard the armed commit; no update_pulse SHALL follow the release of reset.
REQ-042 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-043 Reset, defaults: release reset and read addresses 0..3 from the active copy -> 25, 0, 0, 0; commit_cnt = 0.
REQ-044 Shadowed commit: write reg0 = 40, then read the active copy -> 25; commit_req, then frame_sync 10 cycles later -> active reg0 = 40 on that edge, update_pulse for 1 cycle, commit_cnt = 1.
REQ-045 Collision: with PENDING armed, write reg2 = 7 in the same cycle as frame_sync -> active reg2 keeps its old value, shadow reg2 = 7, commit_pending = 0.
REQ-046 Same-cycle commit: commit_req and frame_sync together in IDLE -> apply on that edge, commit_pending never high.
REQ-047 Address error: write to address 9 with NUM_REGS = 4 -> no register changes, one addr_err pulse; a read of address 9 -> rd_data = 0, rd_valid = 1, addr_err = 1.
REQ-048 Reset mid-commit: pulse rst_n low while PENDING -> all registers back to RST_VALS, and no update_pulse on a later frame_sync.

Source files
------------

// File: rtl/cfg_reg_bank.sv
// Purpose: shadowed configuration register bank; writes land in shadow, commits copy shadow to active on frame_sync.
// Latency: reads return 1 cycle after rd_en; commits apply on the frame_sync edge, update_pulse follows 1 cycle later.
// Backpressure: none; every write/read strobe is accepted every cycle, illegal addresses flag addr_err.
//
// Ports:
//   PCIE_dma_engine_clk, rst_n        clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data             write into shadow copy (and active copy too when IMMEDIATE)
//   rd_en/rd_addr/rd_src              read request, rd_src selects shadow (0) or active (1)
//   rd_data/rd_valid                  registered read result and its one-cycle qualifier
//   commit_req/frame_sync             arm a commit / frame boundary where an armed commit applies
//   active_regs                       packed active image, register 0 in the LSBs
//   commit_pending/update_pulse       commit armed / one-cycle pulse after an apply
//   addr_err/commit_cnt               out-of-range access pulse / wrapping count of applied commits
module cfg_reg_bank #(
   parameter int                         NUM_REGS  = 4,
   parameter int                         DATA_W    = 8,
   parameter int                         ADDR_W    = 4,
   parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS  = {8'd0, 8'd0, 8'd0, 8'd25},
   parameter bit                         IMMEDIATE = 1'b0
) (
   input  logic                         PCIE_dma_engine_clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_addr,
   input  logic                         rd_src,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   input  logic                         commit_req,
   input  logic                         frame_sync,
   output logic [NUM_REGS*DATA_W-1:0]   active_regs,
   output logic                         commit_pending,
   output logic                         update_pulse,
   output logic                         addr_err,
   output logic [7:0]                   commit_cnt
);

   // One extra bit so the limit itself is representable when NUM_REGS == 2^ADDR_W.
   localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                apply;
   logic                wr_ok;
   logic                wr_bad;
   logic                rd_bad;
   logic [DATA_W-1:0]   rd_mux;
   logic [DATA_W-1:0]   shadow_q [NUM_REGS];
   logic [DATA_W-1:0]   active_q [NUM_REGS];

   assign wr_ok  = wr_en && ({1'b0, wr_addr} < REG_LIMIT);
   assign wr_bad = wr_en && ({1'b0, wr_addr} >= REG_LIMIT);
   assign rd_bad = rd_en && ({1'b0, rd_addr} >= REG_LIMIT);

   // Commit FSM: commit_req arms, frame_sync applies. A request coinciding with
   // frame_sync in IDLE applies immediately without ever showing as pending.
   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      case (state_q)
         IDLE: begin
            if (commit_req && frame_sync) begin
               apply = 1'b1;
            end else if (commit_req) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (frame_sync) begin
               apply   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCIE_dma_engine_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign commit_pending = (state_q == PENDING);

   // Register arrays. The apply copies the shadow values as they stood before
   // this edge, so a write in the apply cycle only reaches the shadow copy.
   // In IMMEDIATE mode the write is also mirrored into the active copy and,
   // being later in the block, wins over a coincident apply for that register.
   always_ff @(posedge PCIE_dma_engine_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
            active_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (apply) begin
               active_q[i] <= shadow_q[i];
            end
            if (wr_ok && (wr_addr == ADDR_W'(i))) begin
               shadow_q[i] <= wr_data;
               if (IMMEDIATE) begin
                  active_q[i] <= wr_data;
               end
            end
         end
      end
   end

   // Read mux; an address with no matching register falls through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == ADDR_W'(i)) begin
            rd_mux = rd_src ? active_q[i] : shadow_q[i];
         end
      end
   end

   always_ff @(posedge PCIE_dma_engine_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         update_pulse <= 1'b0;
         addr_err     <= 1'b0;
         commit_cnt   <= 8'd0;
      end else begin
         rd_valid     <= rd_en;
         update_pulse <= apply;
         addr_err     <= wr_bad || rd_bad;
         if (rd_en) begin
            rd_data <= rd_mux;
         end
         if (apply) begin
            commit_cnt <= commit_cnt + 8'd1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_active_out
      assign active_regs[g*DATA_W +: DATA_W] = active_q[g];
   end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Purpose: directed table-driven checks of cfg_reg_bank with default parameters.
// Latency: each vector is driven at a falling edge and checked 1 time unit after the next rising edge.
// Backpressure: not applicable; the bench drives one vector per cycle.
module tb_cfg_reg_bank;

   logic        PCIE_dma_engine_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic        rd_src = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        commit_req = 1'b0;
   logic        frame_sync = 1'b0;
   logic [31:0] active_regs;
   logic        commit_pending;
   logic        update_pulse;
   logic        addr_err;
   logic [7:0]  commit_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 PCIE_dma_engine_clk = ~PCIE_dma_engine_clk;

   cfg_reg_bank dut (
      .PCIE_dma_engine_clk (PCIE_dma_engine_clk),
      .rst_n               (rst_n),
      .wr_en               (wr_en),
      .wr_addr             (wr_addr),
      .wr_data             (wr_data),
      .rd_en               (rd_en),
      .rd_addr             (rd_addr),
      .rd_src              (rd_src),
      .rd_data             (rd_data),
      .rd_valid            (rd_valid),
      .commit_req          (commit_req),
      .frame_sync          (frame_sync),
      .active_regs         (active_regs),
      .commit_pending      (commit_pending),
      .update_pulse        (update_pulse),
      .addr_err            (addr_err),
      .commit_cnt          (commit_cnt)
   );

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [7:0]  wd;
      logic        re;
      logic [3:0]  ra;
      logic        rs;
      logic        cr;
      logic        fs;
      logic [7:0]  e_rd;
      logic        e_rv;
      logic        e_ae;
      logic        e_pend;
      logic        e_upd;
      logic [7:0]  e_cnt;
      logic [31:0] e_act;
   } vec_t;

   function automatic vec_t mk(
      input logic we, input logic [3:0] wa, input logic [7:0] wd,
      input logic re, input logic [3:0] ra, input logic rs,
      input logic cr, input logic fs,
      input logic [7:0] e_rd, input logic e_rv, input logic e_ae,
      input logic e_pend, input logic e_upd, input logic [7:0] e_cnt,
      input logic [31:0] e_act);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd;
      v.re = re; v.ra = ra; v.rs = rs;
      v.cr = cr; v.fs = fs;
      v.e_rd = e_rd; v.e_rv = e_rv; v.e_ae = e_ae;
      v.e_pend = e_pend; v.e_upd = e_upd; v.e_cnt = e_cnt; v.e_act = e_act;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge: drive, wait for the rising edge, check, return at the next falling edge.
   task automatic run_vec(input vec_t v, input string tag);
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      rd_en = v.re; rd_addr = v.ra; rd_src = v.rs;
      commit_req = v.cr; frame_sync = v.fs;
      @(posedge PCIE_dma_engine_clk);
      #1;
      if (v.e_rv) chk({tag, " rd_data"}, 32'(rd_data), 32'(v.e_rd));
      chk({tag, " rd_valid"},       32'(rd_valid),       32'(v.e_rv));
      chk({tag, " addr_err"},       32'(addr_err),       32'(v.e_ae));
      chk({tag, " commit_pending"}, 32'(commit_pending), 32'(v.e_pend));
      chk({tag, " update_pulse"},   32'(update_pulse),   32'(v.e_upd));
      chk({tag, " commit_cnt"},     32'(commit_cnt),     32'(v.e_cnt));
      chk({tag, " active_regs"},    active_regs,         v.e_act);
      @(negedge PCIE_dma_engine_clk);
   endtask

   localparam logic [31:0] ACT_RST = 32'h0000_0019;
   localparam logic [31:0] ACT_A   = 32'h0000_1128;
   localparam logic [31:0] ACT_B   = 32'h3307_1128;

   vec_t tbl [20];
   vec_t idle_pend;

   initial begin
      // Columns: we wa wd | re ra rs | cr fs || rd rv ae pend upd cnt active
      tbl[0]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'd25, 1, 0, 0, 0, 8'd0, ACT_RST); // defaults
      tbl[1]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0, ACT_RST);
      tbl[2]  = mk(0, 0, 8'h00, 1, 2, 1, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0, ACT_RST);
      tbl[3]  = mk(0, 0, 8'h00, 1, 3, 1, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0, ACT_RST);
      tbl[4]  = mk(1, 0, 8'd40, 0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, ACT_RST); // reg0 = 40
      tbl[5]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'd25, 1, 0, 0, 0, 8'd0, ACT_RST); // active still 25
      tbl[6]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'd40, 1, 0, 0, 0, 8'd0, ACT_RST); // shadow 40
      tbl[7]  = mk(1, 9, 8'h55, 0, 0, 0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd0, ACT_RST); // bad write
      tbl[8]  = mk(0, 0, 8'h00, 1, 9, 0, 0, 0, 8'd0,  1, 1, 0, 0, 8'd0, ACT_RST); // bad read
      tbl[9]  = mk(1, 1, 8'h11, 1, 1, 0, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0, ACT_RST); // collision
      tbl[10] = mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h11, 1, 0, 0, 0, 8'd0, ACT_RST);
      tbl[11] = mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 8'd0,  0, 0, 0, 1, 8'd1, ACT_A);   // same-cycle commit
      tbl[12] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd1, ACT_A);
      tbl[13] = mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd1, ACT_A);   // arm
      tbl[14] = mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd1, ACT_A);   // repeat request
      tbl[15] = mk(1, 2, 8'd7,  0, 0, 0, 0, 1, 8'd0,  0, 0, 0, 1, 8'd2, ACT_A);   // write during apply
      tbl[16] = mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'd7,  1, 0, 0, 0, 8'd2, ACT_A);
      tbl[17] = mk(0, 0, 8'h00, 1, 2, 1, 0, 0, 8'd0,  1, 0, 0, 0, 8'd2, ACT_A);
      tbl[18] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'd0,  0, 0, 0, 0, 8'd2, ACT_A);   // idle frame_sync
      tbl[19] = mk(0, 0, 8'h00, 1, 2, 1, 0, 0, 8'd0,  1, 0, 0, 0, 8'd2, ACT_A);

      // Reset state
      repeat (3) @(negedge PCIE_dma_engine_clk);
      chk("rst rd_valid",       32'(rd_valid),       32'd0);
      chk("rst rd_data",        32'(rd_data),        32'd0);
      chk("rst update_pulse",   32'(update_pulse),   32'd0);
      chk("rst addr_err",       32'(addr_err),       32'd0);
      chk("rst commit_cnt",     32'(commit_cnt),     32'd0);
      chk("rst commit_pending", 32'(commit_pending), 32'd0);
      chk("rst active_regs",    active_regs,         ACT_RST);
      rst_n = 1'b1;
      @(negedge PCIE_dma_engine_clk);

      for (int i = 0; i < 20; i++) begin
         run_vec(tbl[i], $sformatf("v%0d", i));
      end

      // Shadowed commit with frame_sync ten cycles after commit_req
      run_vec(mk(1, 3, 8'h33, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd2, ACT_A), "sc wr");
      run_vec(mk(0, 0, 8'h00, 1, 3, 1, 0, 0, 8'd0, 1, 0, 0, 0, 8'd2, ACT_A), "sc rd");
      run_vec(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0, 0, 0, 1, 0, 8'd2, ACT_A), "sc arm");
      idle_pend = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd2, ACT_A);
      for (int i = 0; i < 9; i++) begin
         run_vec(idle_pend, $sformatf("sc wait%0d", i));
      end
      run_vec(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'd0, 0, 0, 0, 1, 8'd3, ACT_B), "sc apply");
      run_vec(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd3, ACT_B), "sc after");

      // Reset while a commit is pending
      run_vec(mk(1, 1, 8'h99, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd3, ACT_B), "rm wr");
      run_vec(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0, 0, 0, 1, 0, 8'd3, ACT_B), "rm arm");
      wr_en = 1'b0; rd_en = 1'b0; commit_req = 1'b0; frame_sync = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rm async active_regs",    active_regs,         ACT_RST);
      chk("rm async commit_pending", 32'(commit_pending), 32'd0);
      chk("rm async commit_cnt",     32'(commit_cnt),     32'd0);
      @(negedge PCIE_dma_engine_clk);
      rst_n = 1'b1;
      // First edge after release must accept a write.
      run_vec(mk(1, 0, 8'h5A, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, ACT_RST), "rm first wr");
      run_vec(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 1, 0, 0, 0, 8'd0, ACT_RST), "rm rd sh0");
      run_vec(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0, ACT_RST), "rm rd sh1");
      run_vec(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'd0,  0, 0, 0, 0, 8'd0, ACT_RST), "rm fsync");
      run_vec(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, ACT_RST), "rm after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
